// File: rtl/ysyx_220053_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Optional flush support is enabled by defining YSYX_220053_MUL_FLUSH_EN.
package ysyx_220053_mul_pkg;
  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  localparam logic [CNT_W-1:0] ITER_D = 7'd64;
  localparam logic [CNT_W-1:0] ITER_W = 7'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    CALC   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_e;
endpackage

// File: rtl/ysyx_220053_Adder64.sv
// Shared 64-bit adder/subtractor: {cout,result} = x + (sub ? ~y : y) + sub.
module ysyx_220053_Adder64 (
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic        sub,
  output logic [63:0] result,
  output logic        cout
);
  always_comb begin
    {cout, result} = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {64'd0, sub};
  end
endmodule

// File: rtl/ysyx_220053_mul_seq.sv
// Radix-2 shift-add multiplier sequencer (MUL/MULH/MULHSU/MULHU/MULW) on one shared adder.
// Define YSYX_220053_MUL_FLUSH_EN to add the flush input.
module ysyx_220053_mul_seq
  import ysyx_220053_mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            mul_word,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] mul_a,
  input  logic [XLEN-1:0] mul_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
`ifdef YSYX_220053_MUL_FLUSH_EN
  input  logic            flush,
`endif
  output state_e          o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised by the producer, is held with stable payload until that edge.

  state_e            r_state, w_state_nx;
  logic [XLEN-1:0]   r_a, r_hi, r_lo, r_res_hi, r_res_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_word, r_sgn_a, r_sgn_b, r_neg, r_c0;

  logic [XLEN-1:0]   w_x, w_y, w_sum;
  logic              w_sub, w_cout, w_flush, w_accept;
  logic [XLEN-1:0]   w_a_nx, w_hi_nx, w_lo_nx, w_res_hi, w_res_lo;
  logic [XLEN:0]     w_ps;
  logic [CNT_W-1:0]  w_cnt_nx, w_iter;
  logic              w_c0_nx;

`ifdef YSYX_220053_MUL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign mul_ready   = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign result_hi   = r_res_hi;
  assign result_lo   = r_res_lo;
  assign o_dbg_state = r_state;
  assign w_iter      = r_word ? ITER_W : ITER_D;

  ysyx_220053_Adder64 u_adder (
    .x      (w_x),
    .y      (w_y),
    .sub    (w_sub),
    .result (w_sum),
    .cout   (w_cout)
  );

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    unique case (r_state)
      IDLE: if (mul_valid && !w_flush) begin
        w_accept   = 1'b1;
        w_state_nx = (!mul_word && mul_signed[1]) ? ABS_A : CALC;
      end
      ABS_A:  w_state_nx = ABS_B;
      ABS_B:  w_state_nx = CALC;
      // One extra CALC cycle after the last iteration keeps latency at ITER+1.
      CALC:   if (r_cnt == w_iter) w_state_nx = r_sgn_a ? NEG_LO : DONE;
      NEG_LO: w_state_nx = NEG_HI;
      NEG_HI: w_state_nx = DONE;
      DONE:   if (out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (w_flush && r_state != IDLE) w_state_nx = IDLE;
  end

  // Adder operand mux; ~hi in NEG_HI is formed as all-ones + ~hi + 1.
  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_sub = 1'b0;
    unique case (r_state)
      ABS_A:  begin w_y = r_a;  w_sub = 1'b1; end
      ABS_B:  begin w_y = r_lo; w_sub = 1'b1; end
      CALC:   begin w_x = r_hi; w_y = r_a; end
      NEG_LO: begin w_y = r_lo; w_sub = 1'b1; end
      NEG_HI: begin w_x = r_c0 ? '0 : '1; w_y = r_hi; w_sub = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_a_nx   = r_a;
    w_hi_nx  = r_hi;
    w_lo_nx  = r_lo;
    w_c0_nx  = r_c0;
    w_cnt_nx = r_cnt;
    w_ps     = {1'b0, r_hi};
    unique case (r_state)
      ABS_A:  if (r_sgn_a && r_a[XLEN-1])  w_a_nx  = w_sum;
      ABS_B:  if (r_sgn_b && r_lo[XLEN-1]) w_lo_nx = w_sum;
      CALC: if (r_cnt != w_iter) begin
        w_ps     = r_lo[0] ? {w_cout, w_sum} : {1'b0, r_hi};
        w_hi_nx  = w_ps[XLEN:1];
        w_lo_nx  = {w_ps[0], r_lo[XLEN-1:1]};
        w_cnt_nx = r_cnt + 7'd1;
      end
      NEG_LO: begin
        if (r_neg) w_lo_nx = w_sum;
        w_c0_nx = w_cout;
      end
      NEG_HI: if (r_neg) w_hi_nx = w_sum;
      default: ;
    endcase
    w_res_hi = r_word ? '0 : w_hi_nx;
    w_res_lo = r_word ? {{32{w_lo_nx[XLEN-1]}}, w_lo_nx[XLEN-1:32]} : w_lo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_word   <= 1'b0;
      r_sgn_a  <= 1'b0;
      r_sgn_b  <= 1'b0;
      r_neg    <= 1'b0;
      r_c0     <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_a     <= mul_word ? {32'd0, mul_a[31:0]} : mul_a;
        r_lo    <= mul_word ? {32'd0, mul_b[31:0]} : mul_b;
        r_hi    <= '0;
        r_cnt   <= '0;
        r_c0    <= 1'b0;
        r_word  <= mul_word;
        r_sgn_a <= !mul_word && mul_signed[1];
        r_sgn_b <= !mul_word && (mul_signed == MUL_SS);
        r_neg   <= !mul_word && ((mul_signed[1] && mul_a[XLEN-1]) ^
                                 ((mul_signed == MUL_SS) && mul_b[XLEN-1]));
      end else if (r_state != IDLE) begin
        r_a   <= w_a_nx;
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_c0  <= w_c0_nx;
        r_cnt <= w_cnt_nx;
      end
      if (w_state_nx == DONE && r_state != DONE) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220053_mul_seq.sv
// Directed bench for ysyx_220053_mul_seq: products, latency, backpressure, async reset, optional flush.
module tb_ysyx_220053_mul_seq;
  import ysyx_220053_mul_pkg::*;

  logic        clk, rst_n;
  logic        mul_valid, mul_ready, mul_word;
  logic [1:0]  mul_signed;
  logic [63:0] mul_a, mul_b;
  logic        out_valid, out_ready;
  logic [63:0] result_hi, result_lo;
  state_e      dbg_state;
`ifdef YSYX_220053_MUL_FLUSH_EN
  logic        flush;
`endif

  int total = 0;
  int bad   = 0;

  ysyx_220053_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .mul_word   (mul_word),
    .mul_signed (mul_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
`ifdef YSYX_220053_MUL_FLUSH_EN
    .flush      (flush),
`endif
    .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; presents one request and lets it be accepted.
  task automatic start_op(input logic w, input logic [1:0] s, input logic [63:0] a,
                          input logic [63:0] b);
    mul_word   = w;
    mul_signed = s;
    mul_a      = a;
    mul_b      = b;
    mul_valid  = 1'b1;
    @(posedge clk); #1;
    mul_valid  = 1'b0;
    mul_a      = 64'hA5A5_A5A5_A5A5_A5A5;
    mul_b      = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, {63'd0, mul_ready}, 64'd1);
    chk({tag, "_valid_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic w, input logic [1:0] s,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eh, input logic [63:0] el, input int elat);
    int lat;
    chk({tag, "_ready_before"}, {63'd0, mul_ready}, 64'd1);
    start_op(w, s, a, b);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_hi"}, result_hi, eh);
    chk({tag, "_lo"}, result_lo, el);
    ack(tag);
  endtask

  initial begin
    int lat;
    logic [63:0] keep_hi, keep_lo;
    rst_n = 1'b0; mul_valid = 1'b0; mul_word = 1'b0; mul_signed = 2'b00;
    mul_a = '0; mul_b = '0; out_ready = 1'b0;
`ifdef YSYX_220053_MUL_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", {63'd0, mul_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_hi", result_hi, 64'd0);
    chk("rst_lo", result_lo, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULHU / MUL unsigned
    run_op("mulhu_max", 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 65);
    run_op("mul_shift", 1'b0, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h10,
           64'h1, 64'h2345_6789_ABCD_EF00, 65);
    // MULH signed*signed
    run_op("mulh_m3x7", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 69);
    run_op("mulh_min2", 1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 64'h0, 69);
    run_op("mulh_lo0", 1'b0, 2'b11, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 69);
    // MULHSU signed*unsigned
    run_op("mulhsu_m1x2", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 69);
    run_op("mulhsu_big", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 69);
    // MULW
    run_op("mulw_basic", 1'b1, 2'b00, 64'h7FFF_FFFF, 64'd2,
           64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulw_junk", 1'b1, 2'b00, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
           64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulw_sgnign", 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
           64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("mulw_pos", 1'b1, 2'b01, 64'hCAFE_0000_0001_0000, 64'h0000_0001_0000_1234,
           64'h0, 64'h0000_0000_1234_0000, 33);

    // Backpressure: results and handshake held while out_ready is low
    start_op(1'b0, 2'b00, 64'h1234_5678_9ABC_DEF0, 64'h10);
    wait_done(lat);
    chk("hold_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_ready", {63'd0, mul_ready}, 64'd0);
      chk("hold_hi", result_hi, 64'h1);
      chk("hold_lo", result_lo, 64'h2345_6789_ABCD_EF00);
    end
    ack("hold");

    // Asynchronous reset in the middle of CALC
    start_op(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_state_before", 64'(dbg_state), 64'(CALC));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, mul_ready}, 64'd1);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_hi", result_hi, 64'd0);
    chk("midrst_lo", result_lo, 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF9,
           64'h0, 64'd21, 69);

`ifdef YSYX_220053_MUL_FLUSH_EN
    // Flush during CALC: back to IDLE, no result, old result kept
    keep_hi = result_hi;
    keep_lo = result_lo;
    start_op(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5);
    repeat (20) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_state", 64'(dbg_state), 64'(IDLE));
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) begin
      @(posedge clk); #1;
      chk("flush_no_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("flush_keep_hi", result_hi, keep_hi);
    chk("flush_keep_lo", result_lo, keep_lo);
    // Flush with a request in IDLE: not accepted
    mul_valid = 1'b1; mul_word = 1'b0; mul_signed = 2'b00;
    mul_a = 64'd9; mul_b = 64'd9;
    flush = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    flush = 1'b0;
    chk("flush_noacc_state", 64'(dbg_state), 64'(IDLE));
    run_op("after_flush", 1'b0, 2'b00, 64'd6, 64'd7, 64'd0, 64'd42, 65);
`else
    keep_hi = result_hi;
    keep_lo = result_lo;
    chk("keep_hi", keep_hi, 64'h0);
    chk("keep_lo", keep_lo, 64'd21);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
